// File: rtl/output_buffer.sv
// Result buffer: results are written into ram_o, then drained over a valid/ready port.
// Define OUTPUT_BUFFER_RELU_EN to clamp negative drained words to zero.

`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef ADDR_SIZE
`define ADDR_SIZE 8
`endif

module ram_o #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clka,
    input  logic [AW-1:0] addra,
    input  logic          ena,
    input  logic          wea,
    input  logic [DW-1:0] dina,
    output logic [DW-1:0] douta
);
    logic [DW-1:0] mem [1<<AW];

    always_ff @(posedge clka) begin
        if (ena) begin
            if (wea) mem[addra] <= dina;
            douta <= mem[addra];
        end
    end
endmodule

module output_buffer (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   enable,
    input  logic [`ADDR_SIZE-1:0]  res_addr,
    input  logic [`DATA_WIDTH-1:0] res_data,
    input  logic                   res_vld,
    input  logic                   res_done,
    input  logic [`ADDR_SIZE-1:0]  o_len,
    output logic [`DATA_WIDTH-1:0] o_data,
    output logic                   o_valid,
    input  logic                   o_ready,
    output logic                   o_last,
    output logic                   busy,
    output logic                   drain_done
);
    localparam int AW = `ADDR_SIZE;
    localparam int DW = `DATA_WIDTH;

    typedef enum logic {IDLE, DRAIN} state_t;
    state_t state_q, state_d;

    logic [AW-1:0] len_q, rd_addr, out_cnt;
    logic          inflight;
    logic [DW-1:0] fifo_mem [2];
    logic          wr_ptr, rd_ptr;
    logic [1:0]    occ;
    logic          done_q;

    logic          in_idle, in_drain, start, zero_len, finish;
    logic          fifo_empty, hs, last_word, issue, push, pop, wr;
    logic [DW-1:0] ram_q, head, word;

    assign in_idle    = state_q == IDLE;
    assign in_drain   = state_q == DRAIN;
    assign start      = in_idle && enable && res_done && (o_len != '0);
    assign zero_len   = in_idle && enable && res_done && (o_len == '0);
    assign fifo_empty = occ == 2'd0;
    assign o_valid    = in_drain && (!fifo_empty || inflight);
    assign hs         = o_valid && o_ready;
    assign last_word  = out_cnt == len_q - 1'b1;
    assign o_last     = o_valid && last_word;
    assign finish     = hs && last_word;
    assign issue      = in_drain && enable && (rd_addr < len_q)
                     && (occ + {1'b0, inflight} < 2'd2);
    // A landing word bypasses the FIFO only when it is consumed immediately
    assign push       = inflight && !(fifo_empty && hs);
    assign pop        = !fifo_empty && hs;
    assign wr         = in_idle && enable && res_vld;
    assign head       = fifo_empty ? ram_q : fifo_mem[rd_ptr];
    assign drain_done = done_q;

`ifdef OUTPUT_BUFFER_RELU_EN
    assign word = head[DW-1] ? '0 : head;
`else
    assign word = head;
`endif
    assign o_data = o_valid ? word : '0;

    ram_o #(.AW(AW), .DW(DW)) u_ram (
        .clka  (clk),
        .addra (issue ? rd_addr : res_addr),
        .ena   (wr || issue),
        .wea   (wr),
        .dina  (res_data),
        .douta (ram_q)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        unique case (state_q)
            IDLE:  if (start) state_d = DRAIN;
            DRAIN: begin
                busy = 1'b1;
                if (!enable || finish) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            len_q       <= '0;
            rd_addr     <= '0;
            out_cnt     <= '0;
            inflight    <= 1'b0;
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            occ         <= 2'd0;
            done_q      <= 1'b0;
        end else begin
            done_q <= zero_len || (in_drain && enable && finish);
            if (start) begin
                len_q   <= o_len;
                rd_addr <= '0;
                out_cnt <= '0;
            end
            if (start || (in_drain && (!enable || finish))) begin
                inflight <= 1'b0;
                wr_ptr   <= 1'b0;
                rd_ptr   <= 1'b0;
                occ      <= 2'd0;
            end else if (in_drain) begin
                inflight <= issue;
                if (issue) rd_addr <= rd_addr + 1'b1;
                if (hs) out_cnt <= out_cnt + 1'b1;
                if (push) begin
                    fifo_mem[wr_ptr] <= ram_q;
                    wr_ptr           <= ~wr_ptr;
                end
                if (pop) rd_ptr <= ~rd_ptr;
                if (push && !pop)      occ <= occ + 2'd1;
                else if (pop && !push) occ <= occ - 2'd1;
            end
        end
    end
endmodule

// File: tb/tb_output_buffer.sv
// Scoreboard bench for output_buffer: fill, drain, stall, abort, reset, clamp.

`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef ADDR_SIZE
`define ADDR_SIZE 8
`endif

module tb_output_buffer;
    localparam int AW = `ADDR_SIZE;
    localparam int DW = `DATA_WIDTH;

    logic          clk = 1'b0;
    logic          rstn;
    logic          enable;
    logic [AW-1:0] res_addr;
    logic [DW-1:0] res_data;
    logic          res_vld;
    logic          res_done;
    logic [AW-1:0] o_len;
    logic [DW-1:0] o_data;
    logic          o_valid;
    logic          o_ready;
    logic          o_last;
    logic          busy;
    logic          drain_done;

    int vectors = 0;
    int miscompares = 0;
    logic [DW-1:0] model [1<<AW];
    logic [DW-1:0] exp_q [$];
    int pat [6] = '{1, 0, 0, 1, 0, 1};

    output_buffer dut (
        .clk        (clk),
        .rstn       (rstn),
        .enable     (enable),
        .res_addr   (res_addr),
        .res_data   (res_data),
        .res_vld    (res_vld),
        .res_done   (res_done),
        .o_len      (o_len),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .o_ready    (o_ready),
        .o_last     (o_last),
        .busy       (busy),
        .drain_done (drain_done)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] relu(input logic [DW-1:0] w);
`ifdef OUTPUT_BUFFER_RELU_EN
        return w[DW-1] ? '0 : w;
`else
        return w;
`endif
    endfunction

    task automatic write_mem(input int a, input logic [DW-1:0] d);
        res_addr = AW'(a);
        res_data = d;
        res_vld  = 1'b1;
        model[a] = d;
        @(posedge clk); #1;
        res_vld = 1'b0;
    endtask

    task automatic run_drain(input int len, input bit stall, input string name);
        int cyc = 0;
        int beats = 0;
        int first_v = -1;
        bit exp_done = 0;
        bit done_seen = 0;
        bit was_stall = 0;
        logic [DW-1:0] held = '0;
        logic [DW-1:0] exp;
        for (int a = 0; a < len; a++) exp_q.push_back(relu(model[a]));
        o_len    = AW'(len);
        res_done = 1'b1;
        o_ready  = 1'b1;
        while (!done_seen && cyc < 200) begin
            @(negedge clk);
            if (o_valid && first_v < 0) first_v = cyc;
            if (exp_done) begin
                vectors++;
                done_seen = 1;
                if (drain_done !== 1'b1 || busy !== 1'b0) begin
                    miscompares++;
                    $display("FAIL %s done: drain_done=%b busy=%b, want 1/0",
                             name, drain_done, busy);
                end
            end else if (drain_done) begin
                vectors++;
                miscompares++;
                done_seen = 1;
                $display("FAIL %s early_done at cycle %0d", name, cyc);
            end
            if (was_stall) begin
                vectors++;
                if (o_valid !== 1'b1 || o_data !== held) begin
                    miscompares++;
                    $display("FAIL %s hold: valid=%b data=%h, want 1/%h",
                             name, o_valid, o_data, held);
                end
            end
            if (o_valid && o_ready && !exp_done) begin
                beats++;
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL %s extra_beat data=%h", name, o_data);
                end else begin
                    exp = exp_q.pop_front();
                    if (o_data !== exp || o_last !== 1'(exp_q.size() == 0)) begin
                        miscompares++;
                        $display("FAIL %s beat%0d: data=%h last=%b, want %h/%b",
                                 name, beats - 1, o_data, o_last, exp,
                                 exp_q.size() == 0);
                    end
                    if (exp_q.size() == 0) exp_done = 1;
                end
            end
            was_stall = o_valid && !o_ready;
            held = o_data;
            @(posedge clk); #1;
            res_done = 1'b0;
            cyc++;
            o_ready = stall ? 1'(pat[cyc % 6]) : 1'b1;
        end
        vectors++;
        if (!done_seen || first_v != 2 || beats != len) begin
            miscompares++;
            $display("FAIL %s summary: done=%0d first_valid=%0d beats=%0d, want 1/2/%0d",
                     name, done_seen, first_v, beats, len);
        end
        exp_q.delete();
        o_ready = 1'b1;
    endtask

    task automatic test_reset;
        rstn = 1'b0; enable = 1'b0; res_addr = '0; res_data = '0;
        res_vld = 1'b0; res_done = 1'b0; o_len = '0; o_ready = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (o_valid !== 1'b0 || o_last !== 1'b0 || busy !== 1'b0 ||
            drain_done !== 1'b0 || o_data !== '0) begin
            miscompares++;
            $display("FAIL reset: valid=%b last=%b busy=%b done=%b data=%h, want zeros",
                     o_valid, o_last, busy, drain_done, o_data);
        end
        @(posedge clk); #1;
        rstn = 1'b1;
        enable = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        write_mem(0, 8'h11);
        write_mem(1, 8'h22);
        write_mem(2, 8'h33);
        write_mem(3, 8'h44);
        run_drain(4, 0, "basic");
    endtask

    task automatic test_stall;
        run_drain(4, 1, "stall");
    endtask

    task automatic test_zero_len;
        int pulses = 0;
        int done_cyc = -1;
        bit v_seen = 0;
        bit b_seen = 0;
        o_len = '0;
        res_done = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (o_valid) v_seen = 1;
            if (busy) b_seen = 1;
            if (drain_done) begin
                pulses++;
                done_cyc = c;
            end
            @(posedge clk); #1;
            res_done = 1'b0;
        end
        vectors++;
        if (pulses != 1 || done_cyc != 1 || v_seen || b_seen) begin
            miscompares++;
            $display("FAIL zero_len: pulses=%0d at=%0d valid=%0d busy=%0d, want 1/1/0/0",
                     pulses, done_cyc, v_seen, b_seen);
        end
    endtask

    task automatic test_single;
        write_mem(0, 8'h3C);
        run_drain(1, 0, "single");
    endtask

    task automatic test_abort;
        int beats = 0;
        int cyc = 0;
        int pulses = 0;
        for (int i = 0; i < 8; i++) write_mem(i, DW'(i * 7 + 3));
        o_len = AW'(8);
        res_done = 1'b1;
        o_ready = 1'b1;
        while (beats < 2 && cyc < 20) begin
            @(negedge clk);
            if (o_valid && o_ready) begin
                vectors++;
                if (o_data !== relu(model[beats])) begin
                    miscompares++;
                    $display("FAIL abort_beat%0d: data=%h, want %h",
                             beats, o_data, relu(model[beats]));
                end
                beats++;
            end
            @(posedge clk); #1;
            res_done = 1'b0;
            cyc++;
        end
        if (beats < 2) begin
            vectors++;
            miscompares++;
            $display("FAIL abort_timeout: beats=%0d, want 2", beats);
        end
        enable = 1'b0;
        o_ready = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        vectors++;
        if (o_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_idle: valid=%b busy=%b, want 0/0", o_valid, busy);
        end
        for (int c = 0; c < 4; c++) begin
            if (drain_done) pulses++;
            @(negedge clk);
        end
        vectors++;
        if (pulses != 0) begin
            miscompares++;
            $display("FAIL abort_done: pulses=%0d, want 0", pulses);
        end
        @(posedge clk); #1;
        enable = 1'b1;
        run_drain(4, 0, "restart");
    endtask

    task automatic test_relu;
        write_mem(0, 8'hF0);
        write_mem(1, 8'h05);
        run_drain(2, 1, "relu");
    endtask

    task automatic test_reset_mid_drain;
        write_mem(0, 8'h11);
        write_mem(1, 8'h22);
        write_mem(2, 8'h33);
        write_mem(3, 8'h44);
        o_len = AW'(4);
        res_done = 1'b1;
        o_ready = 1'b1;
        @(posedge clk); #1;
        res_done = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (o_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_pre: valid=%b, want 1", o_valid);
        end
        rstn = 1'b0;
        #1;
        vectors++;
        if (o_valid !== 1'b0 || busy !== 1'b0 || o_data !== '0) begin
            miscompares++;
            $display("FAIL mid_reset: valid=%b busy=%b data=%h, want 0/0/0",
                     o_valid, busy, o_data);
        end
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
        run_drain(4, 0, "retain");
    endtask

    initial begin
        test_reset;
        test_basic;
        test_stall;
        test_zero_len;
        test_single;
        test_abort;
        test_relu;
        test_reset_mid_drain;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
